// File: rtl/csa_resolve_if.sv
// Handshake bundle for the carry-save resolver: operand pair in, binary result out.
interface csa_resolve_if #(
    parameter int DW = 16
);
    logic [DW-1:0] s;
    logic [DW-1:0] c;
    logic          in_valid;
    logic          in_ready;
    logic [DW+1:0] sum;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output s, c, in_valid, out_ready,
        input  in_ready, sum, out_valid
    );

    modport slave (
        input  s, c, in_valid, out_ready,
        output in_ready, sum, out_valid
    );
endinterface

// File: rtl/csa_resolve.sv
// Sequential carry-propagate resolver: sum = s + (c << 1), CW bits per cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// BUSY  | adding chunk k of the latched operands, carry held in cy_q
// DONE  | result held on sum with out_valid until out_ready
module csa_resolve #(
    parameter int DW = 16,
    parameter int CW = 4
) (
    input logic          clk,
    input logic          nreset,
    csa_resolve_if.slave bus
);
    localparam int N  = DW / CW;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_nx;
    logic          hi_q;
    logic          cy_q;
    logic [KW-1:0] k_q;
    logic [DW+1:0] sum_q;
    logic [CW:0]   add_res;
    logic          last;
    int            base;

    assign last = (k_q == KW'(N - 1));

    // One CW-bit adder shared across all chunks, selected by k.
    always_comb begin
        base    = int'(k_q) * CW;
        add_res = {1'b0, a_q[base +: CW]} + {1'b0, b_q[base +: CW]} + {{CW{1'b0}}, cy_q};
        r_nx    = r_q;
        r_nx[base +: CW] = add_res[CW-1:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = BUSY;
            BUSY:    if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            hi_q  <= 1'b0;
            cy_q  <= 1'b0;
            k_q   <= '0;
            sum_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q  <= bus.s;
                        b_q  <= {bus.c[DW-2:0], 1'b0};
                        hi_q <= bus.c[DW-1];
                        cy_q <= 1'b0;
                        k_q  <= '0;
                    end
                end
                BUSY: begin
                    cy_q <= add_res[CW];
                    r_q  <= r_nx;
                    k_q  <= k_q + KW'(1);
                    // The dropped top carry bit (weight 2^DW) folds in with the final carry-out.
                    if (last) begin
                        sum_q <= {hi_q & add_res[CW], hi_q ^ add_res[CW], r_nx};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
endmodule
